// File: rtl/audio_dac_pkg.sv
// Shared definitions for the I2S DAC transmitter: register addresses,
// status/control bit positions and the serializer sequencing states.
package audio_dac_pkg;

   typedef enum logic [1:0] {
      ADDR_LEFT   = 2'd0,
      ADDR_RIGHT  = 2'd1,
      ADDR_STATUS = 2'd2,
      ADDR_CTRL   = 2'd3
   } regAddr_e;

   localparam int ST_SPACE    = 0;
   localparam int ST_UNDERRUN = 1;
   localparam int ST_OVERFLOW = 2;
   localparam int CTRL_EN     = 0;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_WAIT_RISE,
      TX_WAIT_FALL,
      TX_RUN
   } txState_e;

   function automatic logic [31:0] packStatus(input logic space,
                                              input logic underrun,
                                              input logic overflow);
      logic [31:0] word;
      word              = '0;
      word[ST_SPACE]    = space;
      word[ST_UNDERRUN] = underrun;
      word[ST_OVERFLOW] = overflow;
      return word;
   endfunction

endpackage

// File: rtl/audio_dac_i2s_tx_if.sv
// Avalon-MM slave bus carrying the sample/status/control register accesses.
interface audio_dac_i2s_tx_if;

   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );

endinterface

// File: rtl/audio_dac_i2s_tx_bclk_gen.sv
// Bit-clock divider: BCLK toggles every BCLK_DIV clk cycles while enabled and
// flags the clk cycle whose closing edge makes BCLK rise or fall.
module audio_bclk_gen #(
   parameter int BCLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_enable,
   output logic o_bclk,
   output logic o_fallPulse,
   output logic o_risePulse
);

   localparam int CW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

   logic [CW-1:0] r_divCnt;
   logic          r_bclk;
   logic          w_terminal;

   assign w_terminal = i_enable && (r_divCnt == CW'(BCLK_DIV - 1));

   // Clearing on !enable makes BCLK restart low with a full half-period.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_divCnt <= '0;
         r_bclk   <= 1'b0;
      end else if (!i_enable) begin
         r_divCnt <= '0;
         r_bclk   <= 1'b0;
      end else if (w_terminal) begin
         r_divCnt <= '0;
         r_bclk   <= ~r_bclk;
      end else begin
         r_divCnt <= r_divCnt + 1'b1;
      end
   end

   assign o_bclk      = r_bclk;
   assign o_fallPulse = w_terminal && r_bclk;
   assign o_risePulse = w_terminal && !r_bclk;

endmodule

// File: rtl/audio_dac_i2s_tx.sv
// Avalon-MM register block plus I2S serializer: one-deep stereo staging pair,
// one frame loaded per LRCK period, standard one-BCLK data delay.
module audio_dac_i2s_tx
   import audio_dac_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int BCLK_DIV   = 4
) (
   input  logic              clk,
   input  logic              reset,
   audio_dac_i2s_tx_if.slave bus,
   output logic              dac_bclk,
   output logic              dac_lrck,
   output logic              dac_dat
);

   localparam int FRAME_BITS = 2 * DATA_WIDTH;
   localparam int BW         = $clog2(FRAME_BITS);

   logic [DATA_WIDTH-1:0] r_left;
   logic [DATA_WIDTH-1:0] r_right;
   logic                  r_pend;
   logic                  r_underrun;
   logic                  r_overflow;
   logic                  r_enable;
   logic [BW-1:0]         r_bitCnt;
   logic [FRAME_BITS-1:0] r_shift;
   logic                  r_lrck;
   logic                  r_dat;
   logic [31:0]           r_readdata;
   txState_e              r_state;

   txState_e              w_stateNext;
   logic                  w_bclk;
   logic                  w_fallPulse;
   logic                  w_risePulse;
   logic                  w_shiftFall;
   logic                  w_firstFall;
   logic [BW-1:0]         w_bitNext;
   logic                  w_load;
   logic                  w_wr;
   logic                  w_wrLeft;
   logic                  w_wrRight;
   logic                  w_wrStatus;
   logic                  w_wrCtrl;
   logic                  w_acceptRight;

   audio_bclk_gen #(
      .BCLK_DIV (BCLK_DIV)
   ) u_bclkGen (
      .clk         (clk),
      .reset       (reset),
      .i_enable    (r_enable),
      .o_bclk      (w_bclk),
      .o_fallPulse (w_fallPulse),
      .o_risePulse (w_risePulse)
   );

   assign w_wr       = bus.chipselect && !bus.write_n;
   assign w_wrLeft   = w_wr && (bus.address == ADDR_LEFT);
   assign w_wrRight  = w_wr && (bus.address == ADDR_RIGHT);
   assign w_wrStatus = w_wr && (bus.address == ADDR_STATUS);
   assign w_wrCtrl   = w_wr && (bus.address == ADDR_CTRL);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= TX_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Startup waits for a full BCLK high phase so the first fall is a clean left-slot start.
   always_comb begin
      w_stateNext = r_state;
      if (!r_enable) begin
         w_stateNext = TX_IDLE;
      end else begin
         case (r_state)
            TX_IDLE:      w_stateNext = TX_WAIT_RISE;
            TX_WAIT_RISE: if (w_risePulse) w_stateNext = TX_WAIT_FALL;
            TX_WAIT_FALL: if (w_fallPulse) w_stateNext = TX_RUN;
            TX_RUN:       w_stateNext = TX_RUN;
            default:      w_stateNext = TX_IDLE;
         endcase
      end
   end

   always_comb begin
      w_shiftFall = 1'b0;
      w_firstFall = 1'b0;
      case (r_state)
         TX_WAIT_FALL: begin
            w_shiftFall = w_fallPulse;
            w_firstFall = w_fallPulse;
         end
         TX_RUN:       w_shiftFall = w_fallPulse;
         default:      w_shiftFall = 1'b0;
      endcase
   end

   always_comb begin
      w_bitNext = '0;
      if (!w_firstFall && (r_bitCnt != BW'(FRAME_BITS - 1))) begin
         w_bitNext = r_bitCnt + 1'b1;
      end
   end

   assign w_load        = w_shiftFall && (w_bitNext == '0);
   assign w_acceptRight = w_wrRight && (!r_pend || w_load);

   // A load in the same cycle frees the slot, so a coincident RIGHT write is not an overflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_left     <= '0;
         r_right    <= '0;
         r_pend     <= 1'b0;
         r_underrun <= 1'b0;
         r_overflow <= 1'b0;
         r_enable   <= 1'b0;
      end else begin
         if (w_wrLeft) r_left <= bus.writedata[DATA_WIDTH-1:0];
         if (w_acceptRight) r_right <= bus.writedata[DATA_WIDTH-1:0];
         if (w_wrCtrl) r_enable <= bus.writedata[CTRL_EN];

         if (w_acceptRight) r_pend <= 1'b1;
         else if (w_load) r_pend <= 1'b0;

         if (w_load && !r_pend) r_underrun <= 1'b1;
         else if (w_wrStatus && bus.writedata[ST_UNDERRUN]) r_underrun <= 1'b0;

         if (w_wrRight && !w_acceptRight) r_overflow <= 1'b1;
         else if (w_wrStatus && bus.writedata[ST_OVERFLOW]) r_overflow <= 1'b0;
      end
   end

   // The bit leaving the shifter's MSB belongs to slot position bit_cnt-1, giving the I2S delay.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bitCnt <= '0;
         r_shift  <= '0;
         r_lrck   <= 1'b0;
         r_dat    <= 1'b0;
      end else if (!r_enable) begin
         r_bitCnt <= '0;
         r_shift  <= '0;
         r_lrck   <= 1'b0;
         r_dat    <= 1'b0;
      end else if (w_shiftFall) begin
         r_bitCnt <= w_bitNext;
         r_lrck   <= (w_bitNext >= BW'(DATA_WIDTH));
         r_dat    <= r_shift[FRAME_BITS-1];
         if (w_load) r_shift <= r_pend ? {r_left, r_right} : '0;
         else r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_readdata <= '0;
      end else begin
         case (regAddr_e'(bus.address))
            ADDR_LEFT:   r_readdata <= 32'(r_left);
            ADDR_RIGHT:  r_readdata <= 32'(r_right);
            ADDR_STATUS: r_readdata <= packStatus(!r_pend, r_underrun, r_overflow);
            ADDR_CTRL:   r_readdata <= 32'(r_enable);
            default:     r_readdata <= '0;
         endcase
      end
   end

   assign bus.readdata = r_readdata;
   assign dac_bclk     = w_bclk;
   assign dac_lrck     = r_lrck;
   assign dac_dat      = r_dat;

endmodule

// File: tb/tb_audio_dac_i2s_tx.sv
// Directed bench for audio_dac_i2s_tx: register map, frame serialization,
// underrun/overflow flags, load-coincident writes, disable and async reset.
module tb_audio_dac_i2s_tx;
   import audio_dac_pkg::*;

   localparam int DW        = 16;
   localparam int DIV       = 2;
   localparam int FRAME_CYC = 2 * DW * 2 * DIV;
   localparam logic [31:0] LRCK_PATTERN = 32'h0001_FFFE;

   logic clk;
   logic reset;
   logic dacBclk;
   logic dacLrck;
   logic dacDat;

   int          checks      = 0;
   int          failures    = 0;
   int          cyc         = 0;
   int          enableEpoch = 0;
   int          framesDone  = 0;
   int          lastLoadCyc = 0;
   logic [31:0] lastData    = '0;
   logic [31:0] lastLrck    = '0;

   audio_dac_i2s_tx_if avBus();

   audio_dac_i2s_tx #(
      .DATA_WIDTH (DW),
      .BCLK_DIV   (DIV)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (avBus),
      .dac_bclk (dacBclk),
      .dac_lrck (dacLrck),
      .dac_dat  (dacDat)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Receiver model: I2S samples DAT/LRCK on BCLK rises; the rise after the fall
   // with bit_cnt=b carries frame bit b-1, and bit_cnt=0 closes the previous frame.
   initial begin : monitor
      int          seenEpoch;
      int          fallCount;
      int          b;
      logic        prevBclk;
      logic [31:0] curData;
      logic [31:0] curLrck;
      seenEpoch = 0;
      fallCount = -1;
      prevBclk  = 1'b0;
      curData   = '0;
      curLrck   = '0;
      forever begin
         @(negedge clk);
         if (seenEpoch != enableEpoch) begin
            seenEpoch = enableEpoch;
            fallCount = -1;
         end
         if (prevBclk && !dacBclk) begin
            fallCount++;
            if (fallCount % (2 * DW) == 0) lastLoadCyc = cyc;
         end else if (!prevBclk && dacBclk && fallCount >= 0) begin
            b = fallCount % (2 * DW);
            if (b != 0) begin
               curData[32 - b] = dacDat;
               curLrck[32 - b] = dacLrck;
            end else if (fallCount >= 2 * DW) begin
               curData[0] = dacDat;
               curLrck[0] = dacLrck;
               lastData   = curData;
               lastLrck   = curLrck;
               framesDone++;
            end
         end
         prevBclk = dacBclk;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
      avBus.address    = addr;
      avBus.writedata  = data;
      avBus.chipselect = 1'b1;
      avBus.write_n    = 1'b0;
      @(posedge clk);
      #1;
      avBus.chipselect = 1'b0;
      avBus.write_n    = 1'b1;
   endtask

   task automatic checkReg(input string tag, input logic [1:0] addr,
                           input logic [31:0] expected);
      avBus.address = addr;
      @(posedge clk);
      #1;
      checkOutput(tag, avBus.readdata, expected);
   endtask

   task automatic waitFrames(input int target);
      int n;
      n = 0;
      while (framesDone < target && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("frameWait", framesDone, target);
   endtask

   task automatic waitCycle(input int target);
      int n;
      n = 0;
      while (cyc < target && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("cycleWait", cyc, target);
   endtask

   initial begin : stimulus
      int  n;
      logic sawHigh;
      reset            = 1'b1;
      avBus.address    = ADDR_LEFT;
      avBus.chipselect = 1'b0;
      avBus.write_n    = 1'b1;
      avBus.writedata  = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstBclk", {31'b0, dacBclk}, 32'h0);
      checkOutput("rstLrck", {31'b0, dacLrck}, 32'h0);
      checkOutput("rstDat", {31'b0, dacDat}, 32'h0);
      checkOutput("rstReaddata", avBus.readdata, 32'h0);
      reset = 1'b0;
      checkReg("statusIdle", ADDR_STATUS, 32'h1);
      checkReg("ctrlIdle", ADDR_CTRL, 32'h0);

      $display("[TB] basic frame");
      applyStimulus(ADDR_LEFT, 32'h0000_A5F0);
      applyStimulus(ADDR_RIGHT, 32'hFFFF_0F0F);
      checkReg("leftReadback", ADDR_LEFT, 32'h0000_A5F0);
      checkReg("rightReadback", ADDR_RIGHT, 32'h0000_0F0F);
      avBus.address    = ADDR_LEFT;
      avBus.writedata  = 32'h0000_1111;
      avBus.write_n    = 1'b0;
      @(posedge clk);
      #1;
      avBus.write_n    = 1'b1;
      checkReg("leftNoChipselect", ADDR_LEFT, 32'h0000_A5F0);
      checkReg("statusPending", ADDR_STATUS, 32'h0);
      enableEpoch++;
      applyStimulus(ADDR_CTRL, 32'h1);
      n       = 0;
      sawHigh = 1'b0;
      while (n < 20) begin
         @(posedge clk);
         #1;
         n++;
         if (dacBclk) sawHigh = 1'b1;
         else if (sawHigh) break;
      end
      checkOutput("firstFallCycle", n, 32'd4);
      checkReg("statusAfterLoad", ADDR_STATUS, 32'h1);
      waitFrames(1);
      checkOutput("frame1Data", lastData, 32'hA5F0_0F0F);
      checkOutput("frame1Lrck", lastLrck, LRCK_PATTERN);

      $display("[TB] underrun");
      checkReg("statusUnderrun", ADDR_STATUS, 32'h3);
      applyStimulus(ADDR_STATUS, 32'h2);
      checkReg("statusW1C", ADDR_STATUS, 32'h1);
      waitFrames(2);
      checkOutput("frame2Zero", lastData, 32'h0);
      checkReg("statusUnderrunAgain", ADDR_STATUS, 32'h3);

      $display("[TB] overflow");
      applyStimulus(ADDR_STATUS, 32'h6);
      applyStimulus(ADDR_LEFT, 32'h0000_C3C3);
      applyStimulus(ADDR_RIGHT, 32'h0000_1111);
      applyStimulus(ADDR_RIGHT, 32'h0000_2222);
      checkReg("statusOverflow", ADDR_STATUS, 32'h4);
      checkReg("rightKept", ADDR_RIGHT, 32'h0000_1111);
      waitFrames(3);
      checkOutput("frame3Zero", lastData, 32'h0);
      checkReg("statusOvfSticky", ADDR_STATUS, 32'h5);
      applyStimulus(ADDR_STATUS, 32'h6);
      checkReg("statusClearedAll", ADDR_STATUS, 32'h1);
      applyStimulus(ADDR_LEFT, 32'h0000_5A5A);
      applyStimulus(ADDR_RIGHT, 32'h0000_3C3C);
      waitFrames(4);
      checkOutput("frame4Data", lastData, 32'hC3C3_1111);

      $display("[TB] write coincident with load");
      applyStimulus(ADDR_LEFT, 32'h0000_6666);
      applyStimulus(ADDR_RIGHT, 32'h0000_7777);
      waitCycle(lastLoadCyc + FRAME_CYC - 1);
      applyStimulus(ADDR_RIGHT, 32'h0000_2468);
      checkReg("statusCoincident", ADDR_STATUS, 32'h0);
      waitFrames(5);
      checkOutput("frame5Data", lastData, 32'h5A5A_3C3C);
      waitFrames(6);
      checkOutput("frame6Data", lastData, 32'h6666_7777);
      checkReg("statusAfterCoincident", ADDR_STATUS, 32'h1);
      checkReg("rightNewPair", ADDR_RIGHT, 32'h0000_2468);

      $display("[TB] disable mid right slot");
      applyStimulus(ADDR_LEFT, 32'h0000_ABCD);
      applyStimulus(ADDR_RIGHT, 32'h0000_1234);
      waitCycle(lastLoadCyc + 100);
      checkOutput("lrckRightSlot", {31'b0, dacLrck}, 32'h1);
      applyStimulus(ADDR_CTRL, 32'h0);
      @(posedge clk);
      #1;
      checkOutput("offBclk", {31'b0, dacBclk}, 32'h0);
      checkOutput("offLrck", {31'b0, dacLrck}, 32'h0);
      checkOutput("offDat", {31'b0, dacDat}, 32'h0);
      checkReg("ctrlOff", ADDR_CTRL, 32'h0);
      checkReg("statusRetained", ADDR_STATUS, 32'h0);
      enableEpoch++;
      applyStimulus(ADDR_CTRL, 32'h1);
      waitFrames(7);
      checkOutput("reenableData", lastData, 32'hABCD_1234);
      checkOutput("reenableLrck", lastLrck, LRCK_PATTERN);

      $display("[TB] async reset mid frame");
      avBus.address = ADDR_STATUS;
      waitCycle(lastLoadCyc + 66);
      checkOutput("preRstBclk", {31'b0, dacBclk}, 32'h1);
      checkOutput("preRstLrck", {31'b0, dacLrck}, 32'h1);
      checkOutput("preRstReaddata", avBus.readdata, 32'h3);
      reset = 1'b1;
      #1;
      checkOutput("asyncBclk", {31'b0, dacBclk}, 32'h0);
      checkOutput("asyncLrck", {31'b0, dacLrck}, 32'h0);
      checkOutput("asyncDat", {31'b0, dacDat}, 32'h0);
      checkOutput("asyncReaddata", avBus.readdata, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      checkReg("statusPostRst", ADDR_STATUS, 32'h1);
      checkReg("ctrlPostRst", ADDR_CTRL, 32'h0);
      checkReg("leftPostRst", ADDR_LEFT, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
